// File: rtl/msx_mem_bridge_if.sv
// Slot-decoder and SDRAM-controller signal bundle for msx_mem_bridge.
// The bridge is the slave; the decoder/controller side is the master.
interface msx_mem_bridge_if #(
    parameter int ADDR_W = 25
);
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_din;
    logic              req_rd;
    logic              req_we;
    logic [7:0]        req_dout;
    logic              cpu_wait_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_rd;
    logic              mem_we;
    logic [7:0]        mem_dout;
    logic              mem_ready;
    logic              flush;
    logic              timeout_err;

    modport slave (
        input  req_addr, req_din, req_rd, req_we,
        output req_dout, cpu_wait_n,
        output mem_addr, mem_din, mem_rd, mem_we,
        input  mem_dout, mem_ready, flush,
        output timeout_err
    );

    modport master (
        output req_addr, req_din, req_rd, req_we,
        input  req_dout, cpu_wait_n,
        input  mem_addr, mem_din, mem_rd, mem_we,
        output mem_dout, mem_ready, flush,
        input  timeout_err
    );
endinterface

// File: rtl/msx_mem_bridge.sv
// Z80 slot-decoder to SDRAM bridge: one request per CPU cycle,
// WAIT generation, one-entry read-hit register and ready timeout.
module msx_mem_bridge #(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    msx_mem_bridge_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // IDLE and ISSUE already hold WAIT low, so the WAIT state itself
    // lasts TIMEOUT-1 cycles before giving up.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);
    localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);

    logic [1:0]        r_state;
    logic              r_is_wr;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_din;
    logic              r_mem_rd;
    logic              r_mem_we;
    logic [7:0]        r_req_dout;
    logic              r_hit_valid;
    logic [ADDR_W-1:0] r_hit_addr;
    logic [7:0]        r_hit_data;
    logic              r_timeout_err;

    logic w_hit;
    logic w_req;
    logic w_timeout;
    logic w_idle;

    assign w_idle    = (r_state == S_IDLE);
    assign w_hit     = r_hit_valid & ~bus.flush & (bus.req_addr == r_hit_addr);
    assign w_req     = bus.req_we | (bus.req_rd & ~w_hit);
    assign w_timeout = (r_cnt == TO_LAST);

    assign bus.cpu_wait_n  = ~((w_idle & w_req) | (r_state == S_ISSUE)
                               | (r_state == S_WAIT));
    assign bus.req_dout    = r_req_dout;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_din     = r_mem_din;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_we      = r_mem_we;
    assign bus.timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_is_wr       <= 1'b0;
            r_cnt         <= 8'd0;
            r_mem_addr    <= '0;
            r_mem_din     <= 8'd0;
            r_mem_rd      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_req_dout    <= 8'hFF;
            r_hit_valid   <= 1'b0;
            r_hit_addr    <= '0;
            r_hit_data    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_we) begin
                        r_state    <= S_ISSUE;
                        r_is_wr    <= 1'b1;
                        r_mem_addr <= bus.req_addr;
                        r_mem_din  <= bus.req_din;
                        r_mem_we   <= 1'b1;
                    end else if (bus.req_rd && w_hit) begin
                        r_state    <= S_HOLD;
                        r_req_dout <= r_hit_data;
                    end else if (bus.req_rd) begin
                        r_state    <= S_ISSUE;
                        r_is_wr    <= 1'b0;
                        r_mem_addr <= bus.req_addr;
                        r_mem_din  <= bus.req_din;
                        r_mem_rd   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        r_state <= S_HOLD;
                        if (!r_is_wr) begin
                            r_req_dout <= bus.mem_dout;
                            if (!bus.flush) begin
                                r_hit_addr  <= r_mem_addr;
                                r_hit_data  <= bus.mem_dout;
                                r_hit_valid <= 1'b1;
                            end
                        end else if (r_mem_addr == r_hit_addr) begin
                            r_hit_data <= r_mem_din;
                        end
                    end else if (w_timeout) begin
                        r_state       <= S_HOLD;
                        r_req_dout    <= 8'hFF;
                        r_timeout_err <= 1'b1;
                    end else if (r_cnt != TO_MAX) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (!bus.req_rd && !bus.req_we) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Flush overrides any hit-register load in the same cycle.
            if (bus.flush) r_hit_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_msx_mem_bridge.sv
// Randomised bench for msx_mem_bridge with an SDRAM responder and a
// per-CPU-cycle reference model of the hit register and read data.
module tb_msx_mem_bridge;
    localparam int AW = 25;
    localparam int TO = 12;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    msx_mem_bridge_if #(.ADDR_W(AW)) bus ();

    msx_mem_bridge #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]    mem [logic [AW-1:0]];
    bit            m_hv;
    logic [AW-1:0] m_ha;
    logic [7:0]    m_hd;
    logic [7:0]    m_dout;
    bit            m_terr;

    task automatic model_reset();
        m_hv   = 1'b0;
        m_ha   = '0;
        m_hd   = 8'h00;
        m_dout = 8'hFF;
        m_terr = 1'b0;
    endtask

    task automatic drive_idle();
        bus.req_rd    = 1'b0;
        bus.req_we    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    // One CPU memory cycle: levels held until WAIT releases plus hold
    // cycles; the responder answers lat cycles after the request pulse.
    task automatic access(input bit wr, input bit rd,
                          input logic [AW-1:0] a, input logic [7:0] d,
                          input int lat, input int hold, input string nm);
        int c, rdp, wep, low, pc, done_c, exp_low;
        bit ishit, exp_to;
        logic [7:0] rv;
        ishit  = !wr && rd && m_hv && (m_ha == a);
        exp_to = !ishit && (lat < 0);
        rv = 8'h00;
        if (!wr && !ishit) begin
            if (!mem.exists(a)) mem[a] = 8'($urandom);
            rv = mem[a];
        end
        rdp = 0; wep = 0; low = 0; pc = -1; done_c = -1;
        for (c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            bus.req_rd    = rd;
            bus.req_we    = wr;
            bus.req_addr  = a;
            bus.req_din   = d;
            bus.mem_ready = (pc >= 0) && (lat >= 0) && (c == pc + lat);
            bus.mem_dout  = (bus.mem_ready && !wr) ? rv : 8'($urandom);
            @(negedge clk);
            if (bus.mem_rd) rdp++;
            if (bus.mem_we) wep++;
            if ((bus.mem_rd || bus.mem_we) && pc < 0) begin
                pc = c;
                tests++;
                if (bus.mem_addr !== a) begin
                    fails++;
                    $display("FAIL %s addr: got %0h want %0h", nm, bus.mem_addr, a);
                end
                if (wr) begin
                    mem[a] = d;
                    tests++;
                    if (bus.mem_din !== d) begin
                        fails++;
                        $display("FAIL %s din: got %0h want %0h", nm, bus.mem_din, d);
                    end
                end
            end
            if (!bus.cpu_wait_n) low++;
            else if (done_c < 0) done_c = c;
            if (done_c >= 0 && c >= done_c + hold) break;
        end
        tests++;
        if (done_c < 0) begin
            fails++;
            $display("FAIL %s budget: wait still low after %0d cycles", nm, c);
        end
        exp_low = ishit ? 0 : (exp_to ? TO + 1 : lat + 2);
        if (ishit) m_dout = m_hd;
        else if (exp_to) begin
            m_dout = 8'hFF;
            m_terr = 1'b1;
        end else if (wr) begin
            if (a == m_ha) m_hd = d;
        end else begin
            m_dout = rv;
            m_ha   = a;
            m_hd   = rv;
            m_hv   = 1'b1;
        end
        tests++;
        if (rdp !== int'(!wr && !ishit)) begin
            fails++;
            $display("FAIL %s rd_pulses: got %0d want %0d", nm, rdp, int'(!wr && !ishit));
        end
        tests++;
        if (wep !== int'(wr)) begin
            fails++;
            $display("FAIL %s we_pulses: got %0d want %0d", nm, wep, int'(wr));
        end
        tests++;
        if (low !== exp_low) begin
            fails++;
            $display("FAIL %s wait_low: got %0d want %0d", nm, low, exp_low);
        end
        tests++;
        if (bus.req_dout !== m_dout) begin
            fails++;
            $display("FAIL %s dout: got %0h want %0h", nm, bus.req_dout, m_dout);
        end
        tests++;
        if (bus.timeout_err !== m_terr) begin
            fails++;
            $display("FAIL %s terr: got %0b want %0b", nm, bus.timeout_err, m_terr);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        tests++;
        if (bus.cpu_wait_n !== 1'b1) begin
            fails++;
            $display("FAIL %s release: got %0b want 1", nm, bus.cpu_wait_n);
        end
    endtask

    task automatic do_flush();
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        m_hv = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        bus.req_addr = '0;
        bus.req_din  = 8'h00;
        bus.mem_dout = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.mem_rd, bus.mem_we, bus.cpu_wait_n, bus.timeout_err} !== 4'b0010) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0010",
                     {bus.mem_rd, bus.mem_we, bus.cpu_wait_n, bus.timeout_err});
        end
        tests++;
        if (bus.mem_addr !== '0 || bus.mem_din !== 8'h00) begin
            fails++;
            $display("FAIL reset_bus: got %0h/%0h want 0/0", bus.mem_addr, bus.mem_din);
        end
        tests++;
        if (bus.req_dout !== 8'hFF) begin
            fails++;
            $display("FAIL reset_dout: got %0h want ff", bus.req_dout);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_read_miss();
        mem[25'h0004000] = 8'h5A;
        access(1'b0, 1'b1, 25'h0004000, 8'h00, 2, 20, "read_miss");
    endtask

    task automatic test_read_hit();
        access(1'b0, 1'b1, 25'h0004000, 8'h00, 2, 4, "read_hit");
        do_flush();
        access(1'b0, 1'b1, 25'h0004000, 8'h00, 3, 4, "read_after_flush");
    endtask

    task automatic test_write_through();
        access(1'b1, 1'b0, 25'h0004000, 8'hA5, 2, 3, "write");
        access(1'b0, 1'b1, 25'h0004000, 8'h00, 2, 3, "write_through_hit");
    endtask

    task automatic test_simultaneous();
        access(1'b1, 1'b1, 25'h0001000, 8'h3C, 2, 3, "rd_we_both");
        access(1'b0, 1'b1, 25'h0001000, 8'h00, 1, 3, "read_after_both");
    endtask

    task automatic test_timeout();
        access(1'b0, 1'b1, 25'h0002345, 8'h00, -1, 3, "timeout");
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_dout  = 8'h33;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.req_dout !== 8'hFF || bus.timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL late_ready: got %0h/%0b want ff/1", bus.req_dout, bus.timeout_err);
        end
        tests++;
        if (bus.mem_rd !== 1'b0 || bus.cpu_wait_n !== 1'b1) begin
            fails++;
            $display("FAIL late_ready_ctrl: got %0b/%0b want 0/1", bus.mem_rd, bus.cpu_wait_n);
        end
        access(1'b0, 1'b1, 25'h0002345, 8'h00, 2, 3, "read_after_timeout");
    endtask

    task automatic test_reset_mid_wait();
        access(1'b0, 1'b1, 25'h0000777, 8'h00, 2, 3, "preload");
        @(posedge clk); #1;
        bus.req_rd   = 1'b1;
        bus.req_addr = 25'h0000888;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.cpu_wait_n !== 1'b0) begin
            fails++;
            $display("FAIL mid_wait: got %0b want 0", bus.cpu_wait_n);
        end
        reset_n = 1'b0;
        bus.req_rd = 1'b0;
        model_reset();
        #1;
        tests++;
        if (bus.cpu_wait_n !== 1'b1 || bus.mem_rd !== 1'b0 || bus.timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_wait: got %0b/%0b/%0b want 1/0/0",
                     bus.cpu_wait_n, bus.mem_rd, bus.timeout_err);
        end
        tests++;
        if (bus.req_dout !== 8'hFF) begin
            fails++;
            $display("FAIL reset_wait_dout: got %0h want ff", bus.req_dout);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_dout  = 8'h44;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.req_dout !== 8'hFF || bus.cpu_wait_n !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready: got %0h/%0b want ff/1", bus.req_dout, bus.cpu_wait_n);
        end
        access(1'b0, 1'b1, 25'h0000777, 8'h00, 2, 3, "read_after_reset");
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [5];
        logic [AW-1:0] a;
        int r, lat;
        bit wr, rd;
        pool[0] = 25'h0004000;
        pool[1] = 25'h0001000;
        pool[2] = 25'h0000777;
        pool[3] = 25'h1FFFFFF;
        for (int i = 0; i < 40; i++) begin
            pool[4] = 25'($urandom);
            a  = pool[$urandom_range(0, 4)];
            r  = $urandom_range(0, 9);
            wr = (r < 4);
            rd = (r >= 3);
            lat = ($urandom_range(0, 14) == 0) ? -1 : $urandom_range(1, 6);
            if ($urandom_range(0, 5) == 0) do_flush();
            access(wr, rd, a, 8'($urandom), lat, $urandom_range(1, 4), "random");
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_through();
        test_simultaneous();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
